apb_slave_decoder: RTL and testbench

//  Registered APB 1-to-N decoder. It consumes the APB master output of the AHB/AMM->APB bridge
//  and fans it out to N APB slaves, selected by a slot field of PADDR.

---
 rtl/apb_slave_decoder.sv | 177 +++++++++++++++++
 tb/tb_apb_slave_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_decoder.sv
// Registered APB 1-to-N decoder: fans one upstream APB master out to 2**SEL_BITS slaves.
// Optional feature macro APB_DEC_TIMEOUT_EN adds an ACCESS-phase timeout returning PSLVERR.

module apb_dec_slot #(
  parameter int SLOT     = 0,
  parameter int SEL_BITS = 2
) (
  input  logic [SEL_BITS-1:0] slot,
  input  logic                drive,
  input  logic [31:0]         prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic                psel,
  output logic [31:0]         rdata,
  output logic                rdy,
  output logic                err
);
  logic hit;

  // Non-selected lanes contribute zeros so the parent can OR-reduce.
  assign hit   = (slot == SEL_BITS'(SLOT));
  assign psel  = hit & drive;
  assign rdata = hit ? prdata : '0;
  assign rdy   = hit & pready;
  assign err   = hit & pslverr;
endmodule

module apb_slave_decoder #(
  parameter int                       SEL_LSB  = 12,
  parameter int                       SEL_BITS = 2,
  parameter logic [(2**SEL_BITS)-1:0] SLV_EN   = '1,
  parameter int                       TMO_CYC  = 255
) (
  input  logic                         PCLK,
  input  logic                         PRESETN,
  input  logic                         S_PSEL,
  input  logic                         S_PENABLE,
  input  logic [31:0]                  S_PADDR,
  input  logic [31:0]                  S_PWDATA,
  input  logic                         S_PWRITE,
  output logic [31:0]                  S_PRDATA,
  output logic                         S_PREADY,
  output logic                         S_PSLVERR,
  output logic [(2**SEL_BITS)-1:0]     M_PSEL,
  output logic                         M_PENABLE,
  output logic [31:0]                  M_PADDR,
  output logic [31:0]                  M_PWDATA,
  output logic                         M_PWRITE,
  input  logic [32*(2**SEL_BITS)-1:0]  M_PRDATA,
  input  logic [(2**SEL_BITS)-1:0]     M_PREADY,
  input  logic [(2**SEL_BITS)-1:0]     M_PSLVERR
);
  localparam int N = 2**SEL_BITS;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [31:0]         addr_q, wdata_q, rdata_q;
  logic                write_q, err_q, drop_q;
  logic [SEL_BITS-1:0] slot_q, slot_in;
  logic                accept, drive, tmo;

  logic [N-1:0]        lane_psel, lane_rdy, lane_err;
  logic [N-1:0][31:0]  lane_rdata;
  logic                sel_rdy, sel_err;
  logic [31:0]         sel_rdata;

  assign slot_in = S_PADDR[SEL_LSB +: SEL_BITS];
  assign accept  = S_PSEL & ~S_PENABLE;
  assign drive   = (state == SETUP) || (state == ACCESS);

  for (genvar g = 0; g < N; g++) begin : g_slot
    apb_dec_slot #(.SLOT(g), .SEL_BITS(SEL_BITS)) u_slot (
      .slot    (slot_q),
      .drive   (drive),
      .prdata  (M_PRDATA[32*g +: 32]),
      .pready  (M_PREADY[g]),
      .pslverr (M_PSLVERR[g]),
      .psel    (lane_psel[g]),
      .rdata   (lane_rdata[g]),
      .rdy     (lane_rdy[g]),
      .err     (lane_err[g])
    );
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N; i++) sel_rdata |= lane_rdata[i];
  end
  assign sel_rdy = |lane_rdy;
  assign sel_err = |lane_err;

`ifdef APB_DEC_TIMEOUT_EN
  localparam int                CW       = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CW-1:0]     TMO_MAX  = CW'(TMO_CYC);
  localparam logic [CW-1:0]     TMO_LAST = CW'(TMO_CYC - 1);
  logic [CW-1:0] cnt;

  // cnt holds ACCESS cycles already elapsed; this cycle is the TMO_CYC-th one.
  assign tmo = (cnt == TMO_LAST);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)                cnt <= '0;
    else if (state != ACCESS)    cnt <= '0;
    else if (cnt != TMO_MAX)     cnt <= cnt + 1'b1;
  end
`else
  localparam int unused_tmo_cyc = TMO_CYC;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SLV_EN[slot_in] ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_rdy || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      slot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q  <= S_PADDR;
          wdata_q <= S_PWDATA;
          write_q <= S_PWRITE;
          slot_q  <= slot_in;
          rdata_q <= '0;
          err_q   <= ~SLV_EN[slot_in];
          drop_q  <= 1'b0;
        end
        SETUP: if (!S_PSEL) drop_q <= 1'b1;
        ACCESS: begin
          // An abandoned upstream still lets the slave finish; only the reply is dropped.
          if (!S_PSEL) drop_q <= 1'b1;
          if (sel_rdy) begin
            rdata_q <= write_q ? '0 : sel_rdata;
            err_q   <= sel_err;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    M_PENABLE = (state == ACCESS);
    S_PREADY  = (state == RESP) && !drop_q;
    S_PRDATA  = S_PREADY ? rdata_q : '0;
    S_PSLVERR = S_PREADY && err_q;
  end

  assign M_PSEL   = lane_psel;
  assign M_PADDR  = addr_q;
  assign M_PWDATA = wdata_q;
  assign M_PWRITE = write_q;
endmodule

// File: tb/tb_apb_slave_decoder.sv
// Directed bench for apb_slave_decoder: a fully populated instance and one with slot 3 unpopulated.
`timescale 1ns/1ps
module tb_apb_slave_decoder;
  logic         pclk = 1'b0;
  logic         presetn;
  logic         s_psel, s_penable, s_pwrite;
  logic [31:0]  s_paddr, s_pwdata;
  logic [127:0] m_prdata;
  logic [3:0]   m_pready, m_pslverr;

  logic [31:0]  s_prdata, ne_prdata;
  logic         s_pready, s_pslverr, ne_pready, ne_pslverr;
  logic [3:0]   m_psel, ne_psel;
  logic         m_penable, m_pwrite, ne_penable, ne_pwrite;
  logic [31:0]  m_paddr, m_pwdata, ne_paddr, ne_pwdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_slave_decoder #(.SEL_LSB(12), .SEL_BITS(2), .SLV_EN(4'b1111), .TMO_CYC(8)) dut (
    .PCLK(pclk), .PRESETN(presetn),
    .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PADDR(s_paddr), .S_PWDATA(s_pwdata),
    .S_PWRITE(s_pwrite), .S_PRDATA(s_prdata), .S_PREADY(s_pready), .S_PSLVERR(s_pslverr),
    .M_PSEL(m_psel), .M_PENABLE(m_penable), .M_PADDR(m_paddr), .M_PWDATA(m_pwdata),
    .M_PWRITE(m_pwrite), .M_PRDATA(m_prdata), .M_PREADY(m_pready), .M_PSLVERR(m_pslverr)
  );

  apb_slave_decoder #(.SEL_LSB(12), .SEL_BITS(2), .SLV_EN(4'b0111), .TMO_CYC(8)) dut_ne (
    .PCLK(pclk), .PRESETN(presetn),
    .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PADDR(s_paddr), .S_PWDATA(s_pwdata),
    .S_PWRITE(s_pwrite), .S_PRDATA(ne_prdata), .S_PREADY(ne_pready), .S_PSLVERR(ne_pslverr),
    .M_PSEL(ne_psel), .M_PENABLE(ne_penable), .M_PADDR(ne_paddr), .M_PWDATA(ne_pwdata),
    .M_PWRITE(ne_pwrite), .M_PRDATA(m_prdata), .M_PREADY(m_pready), .M_PSLVERR(m_pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic setup(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwdata = wdata; s_pwrite = wr;
  endtask

  task automatic idle_bus();
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = '0; s_pwdata = '0;
    m_prdata = '0; m_pready = '0; m_pslverr = '0;
    #3;
    chk("rst_psel",    32'(m_psel), 32'h0);
    chk("rst_penable", 32'(m_penable), 32'h0);
    chk("rst_pready",  32'(s_pready), 32'h0);
    chk("rst_paddr",   m_paddr, 32'h0);
    tick(); presetn = 1'b1; tick();

    // 1: write slot1, zero-wait
    m_prdata = {32'h0000_0D03, 32'h0000_0D02, 32'h0000_0D01, 32'h0000_0D00};
    m_pready = 4'b0010;
    setup(32'h0000_1004, 32'hA5A5_5A5A, 1'b1); tick();
    chk("t1_psel_c1", 32'(m_psel), 32'h2);
    chk("t1_pen_c1",  32'(m_penable), 32'h0);
    chk("t1_pwdata",  m_pwdata, 32'hA5A5_5A5A);
    chk("t1_paddr",   m_paddr, 32'h0000_1004);
    chk("t1_pwrite",  32'(m_pwrite), 32'h1);
    chk("t1_rdy_c1",  32'(s_pready), 32'h0);
    s_penable = 1'b1; tick();
    chk("t1_psel_c2", 32'(m_psel), 32'h2);
    chk("t1_pen_c2",  32'(m_penable), 32'h1);
    chk("t1_rdy_c2",  32'(s_pready), 32'h0);
    tick();
    chk("t1_rdy_c3",  32'(s_pready), 32'h1);
    chk("t1_err_c3",  32'(s_pslverr), 32'h0);
    chk("t1_rdata_c3", s_prdata, 32'h0);
    chk("t1_psel_c3", 32'(m_psel), 32'h0);
    idle_bus(); m_pready = '0; tick();
    chk("t1_rdy_c4",  32'(s_pready), 32'h0);

    // 2: read slot3 with 3 wait states
    m_prdata = {32'h1234_5678, 32'h0000_0BA2, 32'h0000_0BA1, 32'h0000_0BA0};
    setup(32'h0000_3010, 32'h0, 1'b0); tick();
    chk("t2_psel_c1", 32'(m_psel), 32'h8);
    s_penable = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_pen_acc", 32'(m_penable), 32'h1);
      chk("t2_rdy_acc", 32'(s_pready), 32'h0);
      chk("t2_rdata_acc", s_prdata, 32'h0);
      if (i == 3) m_pready = 4'b1000;
      tick();
    end
    chk("t2_rdy",   32'(s_pready), 32'h1);
    chk("t2_rdata", s_prdata, 32'h1234_5678);
    chk("t2_err",   32'(s_pslverr), 32'h0);
    idle_bus(); m_pready = '0; tick();

    // 3: slot3 unpopulated in dut_ne -> decode error at cycle 1
    m_pready = 4'b1000;
    setup(32'h0000_3000, 32'h0, 1'b0); tick();
    chk("t3_ne_psel",  32'(ne_psel), 32'h0);
    chk("t3_ne_rdy",   32'(ne_pready), 32'h1);
    chk("t3_ne_err",   32'(ne_pslverr), 32'h1);
    chk("t3_ne_rdata", ne_prdata, 32'h0);
    chk("t3_psel",     32'(m_psel), 32'h8);
    s_penable = 1'b1; tick();
    chk("t3_ne_rdy_c2",  32'(ne_pready), 32'h0);
    chk("t3_ne_psel_c2", 32'(ne_psel), 32'h0);
    tick();
    chk("t3_rdy_c3",   32'(s_pready), 32'h1);
    chk("t3_rdata_c3", s_prdata, 32'h1234_5678);
    idle_bus(); m_pready = '0; tick();

    // 5: slave2 ready+error together, then back-to-back accept
    m_pready = 4'b0100; m_pslverr = 4'b0100;
    setup(32'h0000_2000, 32'h0, 1'b0); tick();
    s_penable = 1'b1; tick(); tick();
    chk("t5_rdy", 32'(s_pready), 32'h1);
    chk("t5_err", 32'(s_pslverr), 32'h1);
    tick();
    chk("t5_rdy_idle", 32'(s_pready), 32'h0);
    m_pready = 4'b0010; m_pslverr = '0;
    setup(32'h0000_1000, 32'h1111_2222, 1'b1); tick();
    chk("t5_b2b_psel", 32'(m_psel), 32'h2);
    s_penable = 1'b1; tick(); tick();
    chk("t5_b2b_rdy", 32'(s_pready), 32'h1);
    chk("t5_b2b_err", 32'(s_pslverr), 32'h0);
    idle_bus(); m_pready = '0; tick();

    // 4: slave0 never ready
    m_prdata = {32'h1234_5678, 32'h0000_0BA2, 32'h0000_0BA1, 32'h0000_0BA0};
    setup(32'h0000_0000, 32'h0, 1'b0); tick();
    s_penable = 1'b1; tick();
`ifdef APB_DEC_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("t4_psel_acc", 32'(m_psel), 32'h1);
      chk("t4_rdy_acc",  32'(s_pready), 32'h0);
      tick();
    end
    chk("t4_tmo_rdy",   32'(s_pready), 32'h1);
    chk("t4_tmo_err",   32'(s_pslverr), 32'h1);
    chk("t4_tmo_rdata", s_prdata, 32'h0);
    chk("t4_tmo_psel",  32'(m_psel), 32'h0);
    m_pready = 4'b0001;
    tick();
    chk("t4_late_rdy",  32'(s_pready), 32'h0);
    chk("t4_late_psel", 32'(m_psel), 32'h0);
    chk("t4_late_pen",  32'(m_penable), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("t4_wait_psel", 32'(m_psel), 32'h1);
      chk("t4_wait_rdy",  32'(s_pready), 32'h0);
      tick();
    end
    m_pready = 4'b0001; tick();
    chk("t4_rdy",   32'(s_pready), 32'h1);
    chk("t4_err",   32'(s_pslverr), 32'h0);
    chk("t4_rdata", s_prdata, 32'h0000_0BA0);
`endif
    idle_bus(); m_pready = '0; tick();

    // S_PSEL dropped mid-ACCESS: slave finishes, reply discarded
    setup(32'h0000_1000, 32'h5555_AAAA, 1'b1); tick();
    s_penable = 1'b1; tick();
    idle_bus(); tick();
    chk("drop_psel_acc", 32'(m_psel), 32'h2);
    m_pready = 4'b0010; tick();
    chk("drop_rdy",  32'(s_pready), 32'h0);
    chk("drop_psel", 32'(m_psel), 32'h0);
    m_pready = '0; tick();
    chk("drop_idle_pen", 32'(m_penable), 32'h0);

    // 6: async reset in ACCESS, then a clean transfer
    setup(32'h0000_2000, 32'h0, 1'b0); tick();
    s_penable = 1'b1; tick();
    chk("t6_pen_acc", 32'(m_penable), 32'h1);
    #2 presetn = 1'b0; #1;
    chk("t6_rst_psel",   32'(m_psel), 32'h0);
    chk("t6_rst_pen",    32'(m_penable), 32'h0);
    chk("t6_rst_paddr",  m_paddr, 32'h0);
    chk("t6_rst_rdy",    32'(s_pready), 32'h0);
    chk("t6_rst_pwrite", 32'(m_pwrite), 32'h0);
    idle_bus(); tick(); presetn = 1'b1; tick();
    m_prdata = {32'h1234_5678, 32'hCAFE_F00D, 32'h0000_0BA1, 32'h0000_0BA0};
    m_pready = 4'b0100;
    setup(32'h0000_2004, 32'h0, 1'b0); tick();
    chk("t6_psel",  32'(m_psel), 32'h4);
    chk("t6_paddr", m_paddr, 32'h0000_2004);
    s_penable = 1'b1; tick(); tick();
    chk("t6_rdy",   32'(s_pready), 32'h1);
    chk("t6_rdata", s_prdata, 32'hCAFE_F00D);
    chk("t6_err",   32'(s_pslverr), 32'h0);
    idle_bus(); m_pready = '0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
